// File: rtl/reg5_wr_arbiter.sv
// Round-robin arbiter owning the single write port of a shared 5-bit register.
// One registered grant per cycle; the current holder is masked so it cannot write twice.
module reg5_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic                  stall,
    output logic [NREQ-1:0]       gnt,
    output logic                  write_en,
    output logic [WIDTH-1:0]      reg_in,
    output logic [2:0]            last_id,
    output logic [7:0]            wr_count
);

    logic [NREQ-1:0]  r_gnt;
    logic             r_we;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_last;
    logic [7:0]       r_cnt;
    logic [2:0]       r_ptr;

    logic [NREQ-1:0]  w_elig;
    logic [7:0]       w_elig8;
    logic [WIDTH-1:0] w_data_arr [8];
    logic             w_found;
    logic [2:0]       w_win;
    logic [3:0]       w_idx;
    logic [2:0]       w_next_ptr;
    logic [NREQ-1:0]  w_onehot;
    logic             w_fire;

    assign w_elig  = req & ~r_gnt;
    assign w_elig8 = 8'(w_elig);

    // Unused lanes read as zero so the winner index can stay 3 bits wide.
    for (genvar i = 0; i < 8; i++) begin : g_lane
        if (i < NREQ) begin : g_real
            assign w_data_arr[i] = req_data[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign w_data_arr[i] = '0;
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_idx   = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = 4'(r_ptr) + 4'(k);
            if (w_idx >= 4'(NREQ)) w_idx = w_idx - 4'(NREQ);
            if (!w_found && w_elig8[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[2:0];
            end
        end
    end

    assign w_next_ptr = (4'(w_win) == 4'(NREQ - 1)) ? 3'd0 : w_win + 3'd1;
    assign w_onehot   = NREQ'(1) << w_win;
    assign w_fire     = w_found & ~stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt  <= '0;
            r_we   <= 1'b0;
            r_data <= '0;
            r_last <= 3'd0;
            r_cnt  <= 8'd0;
            r_ptr  <= 3'd0;
        end else begin
            r_gnt <= '0;
            r_we  <= 1'b0;
            if (w_fire) begin
                r_gnt  <= w_onehot;
                r_we   <= 1'b1;
                r_data <= w_data_arr[w_win];
                r_last <= w_win;
                r_ptr  <= w_next_ptr;
                if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign gnt      = r_gnt;
    assign write_en = r_we;
    assign reg_in   = r_data;
    assign last_id  = r_last;
    assign wr_count = r_cnt;

endmodule
